// File: rtl/rotate_seq_pkg.sv
// Shared types and constants for the rotate/shift register command sequencer.
package rotate_seq_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ROL  = 2'b01,
    OP_ROR  = 2'b10,
    OP_ASR  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_SHIFT = 2'b10,
    S_FIN   = 2'b11
  } state_t;

endpackage

// File: rtl/rotate_sequencer_step_counter.sv
// Loadable down-counter for shift steps; flags the terminal count of 1.
module step_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             last
);

  logic [CNT_W-1:0] count;

  // Saturates at zero so a stray decrement can never wrap to the maximum.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == CNT_W'(1));

endmodule

// File: rtl/rotate_sequencer.sv
// Command sequencer driving the 4-bit rotate/shift register control inputs.
//   state   | meaning
//   S_IDLE  | hold register via q_in reload, accept a command
//   S_LOAD  | one-cycle parallel load of latched data
//   S_SHIFT | one rotate/shift edge per cycle until the counter reaches 1
//   S_FIN   | hold register, capture result, pulse done next cycle
module rotate_sequencer
  import rotate_seq_pkg::*;
#(
  parameter int DATA_W = rotate_seq_pkg::DATA_W,
  parameter int CNT_W  = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [CNT_W-1:0]  cmd_steps,
  input  logic [DATA_W-1:0] q_in,
  output logic              ParallelLoadn,
  output logic              RotateRight,
  output logic              ASRight,
  output logic [DATA_W-1:0] Data_IN,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  state_t            state_q;
  state_t            state_d;
  op_t               op_q;
  logic [DATA_W-1:0] data_q;
  logic              accept;
  logic              cnt_last;

  assign accept = cmd_valid && (state_q == S_IDLE);

  step_counter #(.CNT_W(CNT_W)) u_step_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (accept),
    .load_value (cmd_steps),
    .dec        (state_q == S_SHIFT),
    .last       (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op_t'(cmd_op) == OP_LOAD) state_d = S_LOAD;
          else if (cmd_steps == '0)     state_d = S_FIN;
          else                          state_d = S_SHIFT;
        end
      end
      S_LOAD:  state_d = S_FIN;
      S_SHIFT: if (cnt_last) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_LOAD;
      data_q  <= '0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == S_FIN);
      if (accept) begin
        op_q   <= op_t'(cmd_op);
        data_q <= cmd_data;
      end
      if (state_q == S_FIN) result <= q_in;
    end
  end

  // The register has no hold mode, so every non-shift state reloads q_in.
  always_comb begin
    ParallelLoadn = 1'b0;
    RotateRight   = 1'b0;
    ASRight       = 1'b0;
    Data_IN       = q_in;
    cmd_ready     = 1'b0;
    busy          = 1'b1;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_LOAD:  Data_IN = data_q;
      S_SHIFT: begin
        ParallelLoadn = 1'b1;
        RotateRight   = (op_q != OP_ROL);
        ASRight       = (op_q == OP_ASR);
      end
      default: ;
    endcase
  end

endmodule
